tilemap_scroll_writer: RTL
==========================

TILEMAP_SCROLL_WRITER -- requirements
Module: tilemap_scroll_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of queued scroll/priority writes; legal values are 2, 4, 8 or 16.
REQ-002 CLK_6M  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the reset; synchronous, active-high.
REQ-004 CPU_WE  input  1  SHALL be the write strobe, one push per cycle it is high.
REQ-005 CPU_A  input  3  SHALL be the register address: bit 2 = layer; bits 1:0 = 00 hscroll[7:0], 01 {pri[2:0], hscroll[8]}, 10 vscroll.
REQ-006 CPU_D  input  8  SHALL be the write data.
REQ-007 VBLANK  input  1  SHALL be the vertical blank flag from the sync generator.
REQ-008 LATCH  output  1  SHALL be the latch strobe to the tilemap generator.
REQ-009 CA  output  3  SHALL be the register address presented to the tilemap generator.
REQ-010 MDI  output  8  SHALL be the data presented to the tilemap generator.
REQ-011 FULL / EMPTY  output  1 each  SHALL be the FIFO status flags.
REQ-012 BUSY  output  1  SHALL be high in any state other than IDLE.
REQ-013 OVF  output  1  SHALL be the sticky overflow flag.

Function
REQ-014 Each CPU_WE cycle SHALL push {CPU_A, CPU_D} into the FIFO unless occupancy is FIFO_DEPTH.
REQ-015 A push at occupancy FIFO_DEPTH SHALL be dropped and SHALL set OVF, even if a pop occurs in the same cycle.
REQ-016 A simultaneous push and pop below full SHALL leave occupancy unchanged and preserve entry order.
REQ-017 FSM states SHALL be IDLE, SETUP, STROBE and HOLD; each state lasts exactly one cycle except IDLE.
REQ-018 IDLE->SETUP SHALL occur when the FIFO is not empty and the drain gate is open; the head entry is popped on that transition and registered onto CA/MDI.
REQ-019 In SETUP, CA/MDI SHALL be valid with LATCH=0.
REQ-020 In STROBE, LATCH SHALL be 1 with CA/MDI unchanged.
REQ-021 In HOLD, LATCH SHALL be 0 with CA/MDI unchanged.
REQ-022 On leaving HOLD, the FSM SHALL go to SETUP (popping the next entry) if the FIFO is not empty and the gate is open, otherwise to IDLE.
REQ-023 Throughput SHALL be one entry per 3 cycles back-to-back.
REQ-024 Latency from CPU_WE into an empty FIFO (gate open) to LATCH=1 SHALL be 3 cycles.
REQ-025 The drain gate SHALL be sampled only at IDLE and HOLD decision points; a started sequence SHALL complete even if the gate closes.
REQ-026 CA/MDI SHALL retain their last values in IDLE.
REQ-027 The FIFO SHALL use wrap-around read and write pointers; FULL and EMPTY SHALL be derived from occupancy and registered.

Reset
REQ-028 With RST high at a clock edge, the block SHALL set the FSM to IDLE, flush the FIFO and ignore CPU_WE in that cycle.
REQ-029 Reset SHALL drive LATCH=0, CA=0, MDI=0, FULL=0, EMPTY=1, BUSY=0 and OVF=0.
REQ-030 Reset asserted mid-sequence, including during STROBE, SHALL force LATCH=0 on the next cycle; the in-flight entry is discarded.
REQ-031 OVF SHALL be cleared only by reset.

Configuration
REQ-032 With macro SCROLL_WRITER_VBLANK_GATE_EN defined, the drain gate SHALL equal VBLANK, so entries drain only during vertical blank.
REQ-033 Without SCROLL_WRITER_VBLANK_GATE_EN, the drain gate SHALL be constant 1, and the VBLANK input SHALL be ignored.

Verification
REQ-034 Single write, gate open: CPU_A=3'b000, CPU_D=8'h5A at cycle 0 -> SETUP cycle 2 with CA=0, MDI=8'h5A; LATCH=1 in cycle 3 only; BUSY low by cycle 5.
REQ-035 Burst of 4 writes (8'h11, 8'h22, 8'h33, 8'h44) on consecutive cycles -> LATCH pulses every 3 cycles with MDI in push order; FULL=1 after the 4th push if no pop has occurred; EMPTY=1 after the last pop.
REQ-036 Overflow: 5 pushes while the gate is closed (VBLANK=0, macro defined) -> 5th dropped; OVF=1 and stays 1; raising VBLANK drains exactly 4 entries.
REQ-037 Gate closing mid-sequence: VBLANK falls during STROBE -> HOLD completes; FSM goes to IDLE with 2 entries remaining; drain resumes on the next VBLANK.
REQ-038 Reset during STROBE with 3 entries queued -> LATCH=0 next cycle; EMPTY=1, CA=0, MDI=0, OVF=0; no further LATCH pulses.
REQ-039 Simultaneous push and pop at occupancy 2 -> occupancy remains 2; the pushed entry is emitted after the older entry.

Source files
------------

// File: rtl/tilemap_scroll_writer_if.sv
// CPU write port and tilemap-generator register bus for the scroll writer.
// master = CPU / sync side driving writes, slave = the writer block.
interface tilemap_scroll_writer_if;
   logic       CPU_WE;
   logic [2:0] CPU_A;
   logic [7:0] CPU_D;
   logic       VBLANK;
   logic       LATCH;
   logic [2:0] CA;
   logic [7:0] MDI;
   logic       FULL;
   logic       EMPTY;
   logic       BUSY;
   logic       OVF;

   modport master (
      output CPU_WE, CPU_A, CPU_D, VBLANK,
      input  LATCH, CA, MDI, FULL, EMPTY, BUSY, OVF
   );

   modport slave (
      input  CPU_WE, CPU_A, CPU_D, VBLANK,
      output LATCH, CA, MDI, FULL, EMPTY, BUSY, OVF
   );
endinterface

// File: rtl/tilemap_scroll_writer.sv
// Tilemap scroll/priority writer: queues CPU register writes in a small FIFO
// and replays them to the tilemap generator as SETUP / STROBE / HOLD
// sequences (one entry every 3 cycles).
// Optional macro SCROLL_WRITER_VBLANK_GATE_EN: drain only while VBLANK is high.
module tilemap_scroll_writer #(
   parameter int FIFO_DEPTH = 4   // 2, 4, 8 or 16
) (
   input logic                    CLK_6M,
   input logic                    RST,
   tilemap_scroll_writer_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_t;

   state_t        state_q, state_d;
   logic [10:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
   logic [2:0]    ca_q, ca_d;
   logic [7:0]    mdi_q, mdi_d;
   logic          gate, decide, push_en, pop_en;

`ifdef SCROLL_WRITER_VBLANK_GATE_EN
   assign gate = bus.VBLANK;
`else
   // VBLANK is read but has no effect: the gate is always open.
   assign gate = bus.VBLANK | 1'b1;
`endif

   // Gate is only consulted where a new sequence may start.
   assign decide  = (state_q == IDLE) || (state_q == HOLD);
   assign pop_en  = decide && !empty_q && gate;
   // A write at full is dropped even if a pop frees a slot this cycle.
   assign push_en = bus.CPU_WE && !full_q;

   // FIFO pointers, occupancy, flags and head capture onto CA/MDI
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ca_d     = ca_q;
      mdi_d    = mdi_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en) begin
         rd_ptr_d      = rd_ptr_q + PW'(1);
         {ca_d, mdi_d} = mem_q[rd_ptr_q];
      end
      cnt_d   = cnt_q + CW'(push_en) - CW'(pop_en);
      full_d  = (cnt_d == DEPTH_C);
      empty_d = (cnt_d == '0);
      ovf_d   = ovf_q | (bus.CPU_WE & full_q);
   end

   // FIFO / datapath registers
   always_ff @(posedge CLK_6M) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
         ca_q     <= '0;
         mdi_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
         ca_q     <= ca_d;
         mdi_q    <= mdi_d;
      end
   end

   // FIFO storage; writes are suppressed during reset
   always_ff @(posedge CLK_6M) begin
      if (!RST && push_en) mem_q[wr_ptr_q] <= {bus.CPU_A, bus.CPU_D};
   end

   // FSM state register
   always_ff @(posedge CLK_6M) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: once SETUP starts the sequence always runs to HOLD
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop_en) state_d = SETUP;
         SETUP:   state_d = STROBE;
         STROBE:  state_d = HOLD;
         HOLD:    state_d = pop_en ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and registered bus drive
   always_comb begin
      bus.LATCH = (state_q == STROBE);
      bus.BUSY  = (state_q != IDLE);
      bus.CA    = ca_q;
      bus.MDI   = mdi_q;
      bus.FULL  = full_q;
      bus.EMPTY = empty_q;
      bus.OVF   = ovf_q;
   end
endmodule
